// File: rtl/regbank_multiport.sv
// Multiport register bank with two registered read ports, one write port and per-register pending bits.
// Optional macro REGBANK_FORWARD_EN enables write-through bypass on same-cycle read/write collisions.
module regbank_multiport #(
  parameter int ADDR_BITS = 5,
  parameter int WORD_WIDE = 32,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_en_a,
  input  logic [ADDR_BITS-1:0] rd_addr_a,
  output logic [WORD_WIDE-1:0] rd_data_a,
  output logic                 rd_valid_a,
  output logic                 busy_a,
  input  logic                 rd_en_b,
  input  logic [ADDR_BITS-1:0] rd_addr_b,
  output logic [WORD_WIDE-1:0] rd_data_b,
  output logic                 rd_valid_b,
  output logic                 busy_b,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WORD_WIDE-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [ADDR_BITS-1:0] rsv_addr
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_WIDE-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]     pend_q, pend_d;

  logic                 wr_ok, rsv_ok;

  logic [1:0]           en;
  logic [ADDR_BITS-1:0] addr [2];
  logic [WORD_WIDE-1:0] data_q [2];
  logic [WORD_WIDE-1:0] data_d [2];
  logic [1:0]           busy_q, busy_d;
  logic [1:0]           valid_q;

  // Register 0 swallows writes and reservations when hardwired.
  assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

  assign en      = {rd_en_b, rd_en_a};
  assign addr[0] = rd_addr_a;
  assign addr[1] = rd_addr_b;

  always_comb begin
    pend_d = pend_q;
    if (wr_ok)
      pend_d[wr_addr] = 1'b0;
    if (rsv_ok)
      pend_d[rsv_addr] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      data_d[p] = data_q[p];
      busy_d[p] = busy_q[p];
      if (en[p]) begin
        if (ZERO_REG != 0 && addr[p] == '0) begin
          data_d[p] = '0;
          busy_d[p] = 1'b0;
        end else begin
          data_d[p] = mem_q[addr[p]];
          busy_d[p] = pend_q[addr[p]];
`ifdef REGBANK_FORWARD_EN
          // Bypass: the reader sees the write and its pending-clear,
          // unless a same-cycle reservation re-marks the register.
          if (wr_ok && addr[p] == wr_addr) begin
            data_d[p] = wr_data;
            busy_d[p] = rsv_ok && (rsv_addr == addr[p]);
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      pend_q  <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      busy_q  <= '0;
      valid_q <= '0;
    end else begin
      if (wr_ok)
        mem_q[wr_addr] <= wr_data;
      pend_q  <= pend_d;
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      busy_q  <= busy_d;
      valid_q <= en;
    end
  end

  assign rd_data_a  = data_q[0];
  assign rd_data_b  = data_q[1];
  assign busy_a     = busy_q[0];
  assign busy_b     = busy_q[1];
  assign rd_valid_a = valid_q[0];
  assign rd_valid_b = valid_q[1];

endmodule

// File: tb/tb_regbank_multiport.sv
// Directed testbench for regbank_multiport (default parameters).
// Collision expectations follow REGBANK_FORWARD_EN when defined.
module tb_regbank_multiport;

  logic        clock;
  logic        reset;
  logic        rd_en_a, rd_en_b;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  int checks = 0;
  int errors = 0;

  regbank_multiport dut (
    .clock(clock), .reset(reset),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .busy_a(busy_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .busy_b(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a,
                          input logic [31:0] d);
    idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 32'h0
        || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got v=%b d=%h b=%b exp 0/0/0",
               rd_valid_a, rd_data_a, busy_a);
    end
    do_write(5'd5, 32'hDEADBEEF);
    reset = 1'b1;
    tick();
    idle();
    rd_en_a = 1'b1; rd_addr_a = 5'd5;
    tick();
    idle();
    checks++;
    if (rd_data_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_r5_data got %h exp %h", rd_data_a, 32'h0);
    end
    checks++;
    if (busy_a !== 1'b0 || rd_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_r5_flags got b=%b v=%b exp b=0 v=1",
               busy_a, rd_valid_a);
    end
  endtask

  task automatic test_dual_read();
    do_write(5'd3, 32'h11111111);
    do_write(5'd7, 32'h22222222);
    rd_en_a = 1'b1; rd_addr_a = 5'd3;
    rd_en_b = 1'b1; rd_addr_b = 5'd7;
    tick();
    idle();
    checks++;
    if (rd_data_a !== 32'h11111111) begin
      errors++;
      $display("FAIL dual_a got %h exp 11111111", rd_data_a);
    end
    checks++;
    if (rd_data_b !== 32'h22222222) begin
      errors++;
      $display("FAIL dual_b got %h exp 22222222", rd_data_b);
    end
    checks++;
    if (rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL dual_valid got %b%b exp 11",
               rd_valid_a, rd_valid_b);
    end
    tick();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL hold_valid got %b%b exp 00",
               rd_valid_a, rd_valid_b);
    end
    checks++;
    if (rd_data_a !== 32'h11111111
        || rd_data_b !== 32'h22222222) begin
      errors++;
      $display("FAIL hold_data got %h %h exp 11111111 22222222",
               rd_data_a, rd_data_b);
    end
    // same address on both ports
    rd_en_a = 1'b1; rd_addr_a = 5'd7;
    rd_en_b = 1'b1; rd_addr_b = 5'd7;
    tick();
    idle();
    checks++;
    if (rd_data_a !== 32'h22222222
        || rd_data_b !== 32'h22222222) begin
      errors++;
      $display("FAIL same_addr got %h %h exp 22222222 x2",
               rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick();
    idle();
    rd_en_a = 1'b1; rd_addr_a = 5'd0;
    rd_en_b = 1'b1; rd_addr_b = 5'd0;
    tick();
    idle();
    checks++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      errors++;
      $display("FAIL zero_data got %h %h exp 0 0",
               rd_data_a, rd_data_b);
    end
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy got %b%b exp 00", busy_a, busy_b);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle();
    rd_en_a = 1'b1; rd_addr_a = 5'd9;
    rd_en_b = 1'b1; rd_addr_b = 5'd10;
    tick();
    idle();
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL rsv_busy got a=%b b=%b exp a=1 b=0",
               busy_a, busy_b);
    end
    do_write(5'd9, 32'h0000CAFE);
    rd_en_a = 1'b1; rd_addr_a = 5'd9;
    tick();
    idle();
    checks++;
    if (busy_a !== 1'b0 || rd_data_a !== 32'h0000CAFE) begin
      errors++;
      $display("FAIL wr_clear got b=%b d=%h exp b=0 d=0000cafe",
               busy_a, rd_data_a);
    end
    idle();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000BEEF;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle();
    rd_en_a = 1'b1; rd_addr_a = 5'd9;
    tick();
    idle();
    checks++;
    if (busy_a !== 1'b1 || rd_data_a !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL set_wins got b=%b d=%h exp b=1 d=0000beef",
               busy_a, rd_data_a);
    end
  endtask

  task automatic test_collision();
    do_write(5'd4, 32'h0000AAAA);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h00005555;
    rd_en_a = 1'b1; rd_addr_a = 5'd4;
    tick();
    idle();
`ifdef REGBANK_FORWARD_EN
    checks++;
    if (rd_data_a !== 32'h00005555 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL coll_fwd got d=%h b=%b exp 00005555 0",
               rd_data_a, busy_a);
    end
`else
    checks++;
    if (rd_data_a !== 32'h0000AAAA || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL coll_old got d=%h b=%b exp 0000aaaa 0",
               rd_data_a, busy_a);
    end
`endif
    rd_en_a = 1'b1; rd_addr_a = 5'd4;
    tick();
    idle();
    checks++;
    if (rd_data_a !== 32'h00005555) begin
      errors++;
      $display("FAIL coll_next got %h exp 00005555", rd_data_a);
    end
    // write + reserve + read r6 on port B in one cycle
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h00006666;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    rd_en_b = 1'b1; rd_addr_b = 5'd6;
    tick();
    idle();
`ifdef REGBANK_FORWARD_EN
    checks++;
    if (rd_data_b !== 32'h00006666 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL coll_rsv got d=%h b=%b exp 00006666 1",
               rd_data_b, busy_b);
    end
`else
    checks++;
    if (rd_data_b !== 32'h0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL coll_rsv got d=%h b=%b exp 00000000 0",
               rd_data_b, busy_b);
    end
`endif
  endtask

  task automatic test_reset_mid();
    idle();
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h00001234;
    rsv_en = 1'b1; rsv_addr = 5'd2;
    rd_en_a = 1'b1; rd_addr_a = 5'd2;
    tick();
    idle();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_out got v=%b d=%h exp 0 0",
               rd_valid_a, rd_data_a);
    end
    tick();
    checks++;
    if (rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_valid got %b exp 0", rd_valid_a);
    end
    rd_en_a = 1'b1; rd_addr_a = 5'd2;
    rd_en_b = 1'b1; rd_addr_b = 5'd9;
    tick();
    idle();
    checks++;
    if (rd_data_a !== 32'h0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_r2 got d=%h b=%b exp 0 0",
               rd_data_a, busy_a);
    end
    checks++;
    if (rd_data_b !== 32'h0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_r9 got d=%h b=%b exp 0 0",
               rd_data_b, busy_b);
    end
  endtask

  initial begin
    idle();
    rd_addr_a = '0; rd_addr_b = '0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
    reset = 1'b1;
    tick();
    tick();
    idle();
    test_reset();
    test_dual_read();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
